// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the decode stage.
package regfile_pkg;

   localparam int REG_ZERO     = 0;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int POP_MAX_W    = 256;

   // Population count of a bit vector. Narrower vectors are zero-extended by the caller.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX_W; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = DEF_NUM_REGS,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic                iss_en,
   input  logic [ADDR_W-1:0]   iss_addr,
   output logic [NUM_REGS-1:0] pend,
   output logic [ADDR_W:0]     pend_cnt
);

   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

   logic [NUM_REGS-1:0]  pend_nxt;
   logic [POP_MAX_W-1:0] pop_in;

   // Next pending set: clear on writeback, then set on issue so a newer producer wins.
   always_comb begin
      pend_nxt = pend;
      if (wr_en && wr_addr != ZERO_A) pend_nxt[wr_addr] = 1'b0;
      if (iss_en && iss_addr != ZERO_A) pend_nxt[iss_addr] = 1'b1;
      pend_nxt[REG_ZERO] = 1'b0;
      pop_in = '0;
      pop_in[NUM_REGS-1:0] = pend_nxt;
   end

   // Pending bits and their count move together on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         pend_cnt <= '0;
      end else begin
         pend     <= pend_nxt;
         pend_cnt <= (ADDR_W+1)'(popcount(pop_in));
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write bypass and pending-write scoreboard.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int NUM_RD   = 2,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pend;

   // Register storage; writes to r0 are dropped so it stays hardwired to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en && wr_addr != ZERO_A) begin
         regs[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .pend     (pend),
      .pend_cnt (pend_cnt)
   );

   // Per-port read: r0 forces zero, a same-cycle writeback bypasses storage and
   // also satisfies a pending operand.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              hit;
      assign a   = rd_addr[p*ADDR_W +: ADDR_W];
      assign hit = wr_en && (wr_addr == a);
      assign rd_data[p*DATA_W +: DATA_W] = (a == ZERO_A) ? '0 : (hit ? wr_data : regs[a]);
      assign rd_busy[p] = pend[a] && !hit;
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: directed vectors on the default config, reference-model run on a 4-port/16x64 config.
module tb_regfile_mp_sb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default instance: 32x32, 2 read ports
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en, iss_en;
   logic [4:0]  wr_addr, iss_addr;
   logic [31:0] wr_data;
   logic [5:0]  pend_cnt;

   // wide instance: 16x64, 4 read ports
   logic [15:0]  rd_addr_w;
   logic [255:0] rd_data_w;
   logic [3:0]   rd_busy_w;
   logic         wr_en_w, iss_en_w;
   logic [3:0]   wr_addr_w, iss_addr_w;
   logic [63:0]  wr_data_w;
   logic [4:0]   pend_cnt_w;

   regfile_mp_sb dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt));

   regfile_mp_sb #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_w), .rd_data(rd_data_w), .rd_busy(rd_busy_w),
      .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
      .iss_en(iss_en_w), .iss_addr(iss_addr_w), .pend_cnt(pend_cnt_w));

   // kind: 0 = rd_data[port], 1 = rd_busy[port], 2 = pend_cnt
   typedef struct {
      int          inst;
      int          kind;
      int          port;
      logic [63:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic ex(input int inst, input int kind, input int port, input logic [63:0] v, input string n);
      exp_t e;
      e.inst = inst; e.kind = kind; e.port = port; e.val = v; e.name = n;
      q.push_back(e);
   endtask

   function automatic logic [63:0] actual(input int inst, input int kind, input int port);
      if (inst == 0) begin
         case (kind)
            0:       return {32'd0, rd_data[port*32 +: 32]};
            1:       return {63'd0, rd_busy[port]};
            default: return {58'd0, pend_cnt};
         endcase
      end else begin
         case (kind)
            0:       return rd_data_w[port*64 +: 64];
            1:       return {63'd0, rd_busy_w[port]};
            default: return {59'd0, pend_cnt_w};
         endcase
      end
   endfunction

   // Monitor: combinational outputs are presented every cycle; compare mid-cycle.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [63:0] a;
         e = q.pop_front();
         a = actual(e.inst, e.kind, e.port);
         checks++;
         if (a !== e.val) begin
            errors++;
            $display("FAIL %s: inst%0d kind%0d port%0d got %h expected %h", e.name, e.inst, e.kind, e.port, a, e.val);
         end
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   // reference model for the wide instance
   logic [63:0] m_regs [16];
   logic [15:0] m_pend;

   initial begin
      rst_n = 1'b0;
      rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0; iss_en = 0; iss_addr = '0;
      rd_addr_w = '0; wr_en_w = 0; wr_addr_w = '0; wr_data_w = '0; iss_en_w = 0; iss_addr_w = '0;
      cyc; cyc;
      ex(0, 2, 0, 64'd0, "rst_cnt_in_reset");
      rst_n = 1'b1;

      // reset state on every address, both ports
      for (int a = 0; a < 32; a++) begin
         cyc;
         rd2(5'(a), 5'(a));
         ex(0, 0, 0, 64'd0, "rst_rd0");
         ex(0, 0, 1, 64'd0, "rst_rd1");
         ex(0, 1, 0, 64'd0, "rst_busy0");
         ex(0, 1, 1, 64'd0, "rst_busy1");
         ex(0, 2, 0, 64'd0, "rst_cnt");
      end

      // write r1, read back next cycle
      cyc; wr_en = 1; wr_addr = 5'd1; wr_data = 32'd55;
      cyc; wr_en = 0; rd2(5'd0, 5'd1);
      ex(0, 0, 1, 64'd55, "wr_r1_read");

      // same-cycle bypass
      cyc; wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd2(5'd5, 5'd1);
      ex(0, 0, 0, 64'hDEADBEEF, "bypass_r5");
      ex(0, 0, 1, 64'd55, "bypass_other_port");
      cyc; wr_en = 0; rd2(5'd1, 5'd5);
      ex(0, 0, 1, 64'hDEADBEEF, "r5_stored");
      ex(0, 0, 0, 64'd55, "r1_held");

      // r0 is hardwired zero, also under bypass and issue
      cyc; wr_en = 1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd2(5'd0, 5'd0);
      ex(0, 0, 0, 64'd0, "r0_bypass0");
      ex(0, 0, 1, 64'd0, "r0_bypass1");
      cyc; wr_en = 0; iss_en = 1; iss_addr = 5'd0;
      ex(0, 0, 0, 64'd0, "r0_read0");
      ex(0, 0, 1, 64'd0, "r0_read1");
      cyc; iss_en = 0;
      ex(0, 1, 0, 64'd0, "r0_busy");
      ex(0, 2, 0, 64'd0, "r0_cnt");

      // issue r3 then r7
      cyc; iss_en = 1; iss_addr = 5'd3;
      cyc; iss_addr = 5'd7;
      ex(0, 2, 0, 64'd1, "cnt_after_r3");
      cyc; iss_en = 0; rd2(5'd3, 5'd7);
      ex(0, 1, 0, 64'd1, "busy_r3");
      ex(0, 1, 1, 64'd1, "busy_r7");
      ex(0, 2, 0, 64'd2, "cnt_2");

      // writeback r3 = 9: busy drops in the writeback cycle
      cyc; wr_en = 1; wr_addr = 5'd3; wr_data = 32'd9;
      ex(0, 1, 0, 64'd0, "wb_busy_r3");
      ex(0, 0, 0, 64'd9, "wb_data_r3");
      ex(0, 1, 1, 64'd1, "wb_busy_r7");
      ex(0, 2, 0, 64'd2, "wb_cnt_before");
      cyc; wr_en = 0;
      ex(0, 2, 0, 64'd1, "wb_cnt_after");
      ex(0, 1, 0, 64'd0, "r3_clear");
      ex(0, 0, 0, 64'd9, "r3_data");

      // issue and writeback r4 together: set wins
      cyc; iss_en = 1; iss_addr = 5'd4; wr_en = 1; wr_addr = 5'd4; wr_data = 32'd12; rd2(5'd4, 5'd7);
      ex(0, 0, 0, 64'd12, "r4_bypass");
      ex(0, 1, 0, 64'd0, "r4_busy_same");
      cyc; iss_en = 0; wr_en = 0;
      ex(0, 0, 0, 64'd12, "r4_data");
      ex(0, 1, 0, 64'd1, "r4_pending");
      ex(0, 2, 0, 64'd2, "r4_cnt");

      // writeback to a non-pending register; re-issue of pending r7
      cyc; wr_en = 1; wr_addr = 5'd9; wr_data = 32'h99; iss_en = 1; iss_addr = 5'd7;
      cyc; wr_en = 0; iss_en = 0; rd2(5'd9, 5'd7);
      ex(0, 0, 0, 64'h99, "r9_data");
      ex(0, 1, 0, 64'd0, "r9_not_busy");
      ex(0, 1, 1, 64'd1, "r7_still_busy");
      ex(0, 2, 0, 64'd2, "cnt_no_double");

      // asynchronous reset mid-run: visible without a clock edge
      cyc; rst_n = 1'b0; rd2(5'd1, 5'd5);
      ex(0, 0, 0, 64'd0, "arst_r1");
      ex(0, 0, 1, 64'd0, "arst_r5");
      ex(0, 2, 0, 64'd0, "arst_cnt");
      cyc; rst_n = 1'b1; rd2(5'd7, 5'd9);
      ex(0, 1, 0, 64'd0, "arst_busy_r7");
      ex(0, 0, 1, 64'd0, "arst_r9");

      // wide-config regression against a reference model
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_pend = '0;
      for (int n = 0; n < 1000; n++) begin
         cyc;
         // commit the inputs sampled at the edge just passed
         if (wr_en_w && wr_addr_w != 0) begin
            m_regs[wr_addr_w] = wr_data_w;
            m_pend[wr_addr_w] = 1'b0;
         end
         if (iss_en_w && iss_addr_w != 0) m_pend[iss_addr_w] = 1'b1;
         ex(1, 2, 0, 64'($countones(m_pend)), "rnd_cnt");
         // new stimulus
         wr_en_w   = $urandom_range(0, 1) == 1;
         wr_addr_w = 4'($urandom_range(0, 15));
         wr_data_w = {$urandom, $urandom};
         iss_en_w  = $urandom_range(0, 1) == 1;
         iss_addr_w = ($urandom_range(0, 5) == 0) ? wr_addr_w : 4'($urandom_range(0, 15));
         for (int p = 0; p < 4; p++) begin
            logic [3:0]  a;
            logic        hit;
            logic [63:0] d;
            a = ($urandom_range(0, 3) == 0) ? wr_addr_w : 4'($urandom_range(0, 15));
            rd_addr_w[p*4 +: 4] = a;
            hit = wr_en_w && (wr_addr_w == a);
            if (a == 0)   d = '0;
            else if (hit) d = wr_data_w;
            else          d = m_regs[a];
            ex(1, 0, p, d, "rnd_data");
            ex(1, 1, p, {63'd0, m_pend[a] && !hit}, "rnd_busy");
         end
      end

      // drain the scoreboard with a bounded wait
      repeat (3) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised, clocked successor to the single-read-pair MIPS register file, for the decode stage of the pipeline.
- Provides NUM_RD combinational read ports, one synchronous write port, and hardwired-zero register 0.
- Write-to-read bypass means a decode-stage read sees the same-cycle writeback value.
- An integrated pending-write scoreboard flags operands whose producer has issued but not yet written back; hazard/stall logic consumes these flags.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, register count; power of two, >= 2
ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
NUM_RD, 2, number of read ports, 1..4

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = operand i has an outstanding producer
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback value
iss_en  in  1  instruction issued with a destination register
iss_addr  in  ADDR_W  destination of the issued instruction
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear to 0 and all pending bits clear to 0. Outputs then read as rd_data=0, rd_busy=0, pend_cnt=0.
- Reset mid-operation discards all pending state; no write completes in the reset cycle.
- Write: on the rising clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Writes to address 0 are dropped.
- Read (combinational, zero latency), per port i:
  - if rd_addr_i==0: 0;
  - else if wr_en && wr_addr==rd_addr_i: wr_data (bypass);
  - else reg[rd_addr_i].
- Multiple read ports on the same address all return the same value.
- Scoreboard: one pending bit per register; bit 0 is constant 0. At each clock edge:
  - iss_en && iss_addr!=0 sets pend[iss_addr];
  - wr_en && wr_addr!=0 clears pend[wr_addr];
  - same address both set and clear in one cycle: set wins, because a newer producer supersedes the retiring one.
  - Issue to an already-pending register keeps it pending (no counting per register).
- rd_busy_i = pend[rd_addr_i] && !(wr_en && wr_addr==rd_addr_i). A same-cycle writeback satisfies the operand through the bypass. rd_busy_i is always 0 for address 0.
- pend_cnt: registered population count of the pending bits, updated in the same edge as the bits.
  - Range 0..NUM_REGS-1.
  - Must equal popcount(pend) every cycle; no wrap.
- Writeback to a non-pending register is legal: data is written and the pending bit stays 0.
- No X propagation: rd_data is fully defined for every address after reset.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ZERO = 0;
  - default DATA_W / NUM_REGS constants, reused by the pipeline top and the hazard unit;
  - a popcount function.
- Sub-module regfile_scoreboard holds the pending bits, the set/clear priority, and pend_cnt.
- Storage, bypass muxes and the per-port read loop stay in the top module.

Test Plan:
- Reset then read every address on both ports: rd_data=0, rd_busy=0, pend_cnt=0. Assert rst_n low mid-run after writes: all regs read 0 immediately, without waiting for a clock edge.
- Write 32'd55 to r1; next cycle read r1 on port 1 → 55. Same-cycle bypass: wr_en, wr_addr=5, wr_data=32'hDEADBEEF, rd_addr0=5 → rd_data0=DEADBEEF in that cycle.
- Write 32'hFFFFFFFF to r0, then read r0 on both ports → 0. Issue to r0 → rd_busy=0, pend_cnt=0.
- Issue r3, then r7 → pend_cnt=2 and rd_busy=1 for reads of r3/r7. Writeback r3 with 9 → rd_busy=0 during the writeback cycle, rd_data=9, pend_cnt=1 afterwards.
- Issue r4 and writeback r4 (value 12) in the same cycle → r4=12, r4 remains pending, pend_cnt unchanged +1 if previously clear.
- Regression with NUM_RD=4, NUM_REGS=16, DATA_W=64: 1000 random issue/write/read cycles checked against a reference model. rd_data, rd_busy and pend_cnt must match every cycle.
